// File: rtl/dispatch_demux_1x4.sv
// 1-to-4 registered dispatch demux: one upstream valid/ready channel routed by in_sel
// into four one-entry output buffers. Optional per-channel accept counters: DISPATCH_DEMUX_STATS_EN.
module dispatch_demux_1x4 #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_sel,
    input  logic [DATA_W-1:0]   in_data,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic                busy
`ifdef DISPATCH_DEMUX_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [4*16-1:0]     disp_count
`endif
);

    logic [3:0]        vld_p0;
    logic [3:0]        vld_nxt;
    logic [3:0]        free;
    logic [3:0]        acc_vec;
    logic              accept;
    logic [DATA_W-1:0] data_p0 [4];

    // A channel is free when empty or being drained this cycle, so refill has no bubble.
    always_comb begin
        free     = ~vld_p0 | out_ready;
        in_ready = ~flush & ~rst & free[in_sel];
        accept   = in_valid & in_ready;
        acc_vec  = accept ? (4'b0001 << in_sel) : 4'b0000;
        vld_nxt  = flush ? 4'b0000 : (acc_vec | (vld_p0 & ~out_ready));
    end

    // Stage p0: channel buffers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 4'b0000;
        end else begin
            vld_p0 <= vld_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                data_p0[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_vec[i]) begin
                    data_p0[i] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < 4; i++) begin
            out_data[i*DATA_W +: DATA_W] = data_p0[i];
        end
        out_valid = vld_p0;
        busy      = |vld_p0;
    end

`ifdef DISPATCH_DEMUX_STATS_EN
    logic [15:0] cnt_p0 [4];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Clear wins over a same-cycle accept; flush leaves the counters alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_p0[i] <= 16'd0;
            end
        end else if (stats_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_p0[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc_vec[i]) begin
                    cnt_p0[i] <= sat_inc(cnt_p0[i]);
                end
            end
        end
    end

    always_comb begin
        disp_count = '0;
        for (int i = 0; i < 4; i++) begin
            disp_count[i*16 +: 16] = cnt_p0[i];
        end
    end
`endif

endmodule

// File: tb/tb_dispatch_demux_1x4.sv
// Directed testbench for dispatch_demux_1x4; stats scenario runs when DISPATCH_DEMUX_STATS_EN is defined.
module tb_dispatch_demux_1x4;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [1:0]          in_sel = 2'd0;
    logic [DATA_W-1:0]   in_data = '0;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready = 4'b0000;
    logic [4*DATA_W-1:0] out_data;
    logic                busy;
`ifdef DISPATCH_DEMUX_STATS_EN
    logic                stats_clr = 1'b0;
    logic [4*16-1:0]     disp_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    dispatch_demux_1x4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef DISPATCH_DEMUX_STATS_EN
        ,
        .stats_clr (stats_clr),
        .disp_count(disp_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b exp 0000", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
        rst = 1'b0;
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hC0;
        @(negedge clk);
        in_sel = 2'd2; in_data = 32'hC2;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0101) begin n_fail++; $display("FAIL prefill_valid got %b exp 0101", out_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prefill_busy got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL async_rst_valid got %b exp 0000", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %b exp 0", busy); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_in_ready got %b exp 0", in_ready); end
        n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL async_rst_data got %h exp 0", out_data); end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = s[1:0];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready sel=%0d got %b exp 1", s, in_ready); end
        end
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL post_rst_no_pulse got %b exp 0000", out_valid); end
    endtask

    task automatic test_routing;
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = i[1:0]; in_data = 32'hA0 + i;
            @(negedge clk);
            n_cmp++; if (out_valid !== (4'b0001 << i)) begin n_fail++; $display("FAIL route_valid ch%0d got %b exp %b", i, out_valid, 4'b0001 << i); end
            n_cmp++; if (out_data[i*DATA_W +: DATA_W] !== 32'hA0 + i) begin n_fail++; $display("FAIL route_data ch%0d got %h exp %h", i, out_data[i*DATA_W +: DATA_W], 32'hA0 + i); end
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL route_drained got %b exp 0000", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL route_busy got %b exp 0", busy); end
    endtask

    task automatic test_backpressure;
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h55;
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_fill got %b exp 0100", out_valid); end
        in_sel = 2'd2; in_data = 32'h99;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready got %b exp 0", in_ready); end
        in_sel = 2'd1; in_data = 32'h77;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0110) begin n_fail++; $display("FAIL bp_valid got %b exp 0110", out_valid); end
        n_cmp++; if (out_data[1*DATA_W +: DATA_W] !== 32'h77) begin n_fail++; $display("FAIL bp_ch1_data got %h exp 77", out_data[1*DATA_W +: DATA_W]); end
        n_cmp++; if (out_data[2*DATA_W +: DATA_W] !== 32'h55) begin n_fail++; $display("FAIL bp_hold_data got %h exp 55", out_data[2*DATA_W +: DATA_W]); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_still_held got %b exp 0100", out_valid); end
        out_ready = 4'b1111;
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_release got %b exp 0000", out_valid); end
    endtask

    task automatic test_drain_refill;
        out_ready = 4'b0000;
        in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h11;
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b1000 || out_data[3*DATA_W +: DATA_W] !== 32'h11) begin n_fail++; $display("FAIL dr_fill got %b/%h exp 1000/11", out_valid, out_data[3*DATA_W +: DATA_W]); end
        out_ready = 4'b1000;
        in_data = 32'h22;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dr_ready got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL dr_no_bubble got %b exp 1000", out_valid); end
        n_cmp++; if (out_data[3*DATA_W +: DATA_W] !== 32'h22) begin n_fail++; $display("FAIL dr_data got %h exp 22", out_data[3*DATA_W +: DATA_W]); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL dr_drained got %b exp 0000", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = i[1:0]; in_data = 32'h1 + i;
            @(negedge clk);
        end
        n_cmp++; if (out_valid !== 4'b1111) begin n_fail++; $display("FAIL fl_full got %b exp 1111", out_valid); end
        out_ready = 4'b1111;
        flush = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hEE;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_ready got %b exp 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL fl_valid got %b exp 0000", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy got %b exp 0", busy); end
        n_cmp++; if (out_data[0 +: DATA_W] !== 32'h1) begin n_fail++; $display("FAIL fl_not_captured got %h exp 1", out_data[0 +: DATA_W]); end
    endtask

`ifdef DISPATCH_DEMUX_STATS_EN
    task automatic test_stats;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 4'b1111;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h5;
        repeat (70000) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (disp_count[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL st_sat got %h exp FFFF", disp_count[15:0]); end
        n_cmp++; if (disp_count[63:16] !== 48'd0) begin n_fail++; $display("FAIL st_others got %h exp 0", disp_count[63:16]); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (disp_count[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL st_flush_keep got %h exp FFFF", disp_count[15:0]); end
        stats_clr = 1'b1; in_valid = 1'b1; in_sel = 2'd1;
        @(negedge clk);
        stats_clr = 1'b0; in_sel = 2'd2;
        n_cmp++; if (disp_count !== 64'd0) begin n_fail++; $display("FAIL st_clr got %h exp 0", disp_count); end
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (disp_count !== 64'h0000_0003_0000_0000) begin n_fail++; $display("FAIL st_count got %h exp 0000000300000000", disp_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_drain_refill();
        test_flush();
`ifdef DISPATCH_DEMUX_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dispatch_demux_1x4.md
Name: dispatch_demux_1x4

Overview:
- 1-to-4 registered dispatch demultiplexer for the OoO core. It is the inverse of the 4:1 select path.
- Accepts one micro-op per cycle from the rename/dispatch stage on a single valid/ready channel.
- Routes it by a 2-bit select to one of four reservation-station channels. Each channel has a one-entry output buffer with its own valid/ready handshake.
- Supports a synchronous flush for branch-mispredict recovery.

Parameters:
- DATA_W, 32, width of the dispatched payload (micro-op tag/operands) per channel.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all channel buffers.
- in_valid  input  1  upstream has a micro-op on in_data.
- in_ready  output  1  block can accept this cycle.
- in_sel  input  2  destination channel index 0..3.
- in_data  input  DATA_W  payload.
- out_valid  output  4  bit i: channel i buffer holds a micro-op.
- out_ready  input  4  bit i: reservation station i takes the micro-op this cycle.
- out_data  output  4*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- busy  output  1  OR of out_valid.

Behaviour:
- Reset: asynchronous, active-high. While rst=1, out_valid=4'b0000, out_data=all zeros, busy=0, in_ready=0. First accept is possible on the first rising edge after rst deasserts.
- Channel i is "free" when out_valid[i]=0 OR out_ready[i]=1 (drain and refill in the same cycle).
- in_ready = ~flush & ~rst & free[in_sel]. in_ready is combinational from in_sel, out_valid and out_ready. It must not depend on in_valid.
- Accept = in_valid & in_ready. On accept:
  - channel in_sel loads in_data and sets out_valid[in_sel]=1 at the next edge;
  - latency is exactly 1 cycle from accept to out_valid.
- Drain: out_valid[i] & out_ready[i] with no refill of channel i clears out_valid[i] at the next edge. out_data[i] holds its last value; its contents are don't-care when invalid.
- Simultaneous drain and refill of the same channel: out_valid[i] stays 1 and out_data[i] takes the new payload. There is no bubble.
- Channels are independent. A stall on channel j (valid, not ready) never blocks accepts to channel k≠j. Only in_sel=j stalls.
- Holding rule: while out_valid[i]=1 and out_ready[i]=0, out_data[i] is stable.
- Upstream rule: in_data and in_sel are sampled only on accept. They may change freely when in_valid=0.
- Flush (synchronous, highest priority after rst):
  - all out_valid clear at the next edge;
  - no accept occurs in the flush cycle (in_ready=0);
  - any drain in the flush cycle is still considered taken by the downstream station.
- busy = |out_valid. It is registered-derived and glitch-free.
- Reset mid-operation: buffered micro-ops are discarded. No out_valid pulse after reset.

Optional Feature:
- Macro: DISPATCH_DEMUX_STATS_EN.
- Defined: adds output port disp_count (4*16 bits). It holds four 16-bit saturating counters; counter i increments on each accept to channel i and sticks at 16'hFFFF.
  - Counters clear on rst only; flush does not clear them.
  - Adds input port stats_clr (1 bit), which synchronously zeroes all counters. If stats_clr and an accept fall in the same cycle, the counter reads 0 afterwards, since clear has priority.
- Undefined: the disp_count and stats_clr ports and all counter logic are absent. Core dispatch behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream with out_valid=4'b0101 -> out_valid=0, busy=0, in_ready=0 immediately (async). After release, in_ready=1 for any in_sel.
- Routing: send 0xA0..0xA3 with in_sel=0..3 on consecutive cycles, out_ready=4'b1111 -> each out_valid[i] pulses one cycle after its accept with out_data[i]=0xA0+i.
- Backpressure isolation: out_ready[2]=0, channel 2 full with 0x55 -> in_sel=2 gives in_ready=0 and out_data[2] holds 0x55; in_sel=1 with 0x77 is accepted and appears on channel 1 next cycle.
- Drain+refill: channel 3 holds 0x11, out_ready[3]=1, accept 0x22 to channel 3 in the same cycle -> out_valid[3] stays 1 and out_data[3]=0x22 next cycle, with no bubble.
- Flush: out_valid=4'b1111, flush=1 with in_valid=1, in_sel=0 -> in_ready=0 that cycle and out_valid=0 next cycle; the payload is not captured.
- Stats (DISPATCH_DEMUX_STATS_EN): 70000 accepts to channel 0 -> disp_count[15:0]=16'hFFFF, other counters 0. Then stats_clr=1 for one cycle -> all counters 0.
